systolic_feeder: RTL and testbench

Input-side driver for the N×N systolic PE array: buffers one K-deep operand tile arriving over a valid/ready stream, then emits it to the array's left edge (A rows) and top edge (B columns) as uninterrupted, diagonally skewed streams with per-lane valid. The array has no backpressure, so the feeder transmits a whole tile as one burst and owns the inter-tile gap that makes each PE restart its accumulation. It sits between the operand source (DMA/loader) and the array's `a_in`/`b_in`/`valid_in` edge ports.

---
 rtl/systolic_pkg.sv | 21 ++
 rtl/feeder_tile_buf.sv | 26 ++
 rtl/systolic_feeder.sv | 128 ++++++++++++
 tb/tb_systolic_feeder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array input feeder.
package systolic_pkg;

    typedef enum logic {FILL = 1'b0, SEND = 1'b1} feeder_state_e;

    // Counter width that stays at least one bit for depth-1 counters.
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int N_DEF = 4;
    localparam int K_DEF = 4;
    localparam int CNT_W = cw(K_DEF);
    localparam int T_W   = cw(K_DEF + N_DEF - 1);

    // Lane `lane` carries beat k = t - lane; true when that beat exists.
    function automatic logic lane_ok(input int t, input int lane, input int kdepth);
        return (t >= lane) && (t - lane < kdepth);
    endfunction

endpackage

// File: rtl/feeder_tile_buf.sv
// K-entry x N-lane operand store: one beat-wide write port, one read port per lane.
module feeder_tile_buf #(
    parameter int K  = 4,
    parameter int N  = 4,
    parameter int DW = 16,
    parameter int CW = 2
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [CW-1:0]          waddr,
    input  logic [N-1:0][DW-1:0]   wdata,
    input  logic [N-1:0][CW-1:0]   rk,
    output logic [N-1:0][DW-1:0]   rdata
);

    logic [K-1:0][N-1:0][DW-1:0] mem;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    for (genvar i = 0; i < N; i++) begin : g_rd
        assign rdata[i] = mem[rk[i]][i];
    end

endmodule

// File: rtl/systolic_feeder.sv
// Buffers a K-beat operand tile, then bursts it diagonally skewed onto the
// systolic array's A (row) and B (column) edges with per-lane valid.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int N  = 4,
    parameter int K  = 4,
    parameter int DW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] in_a,
    input  logic [N*DW-1:0] in_b,
    output logic [N*DW-1:0] a_out,
    output logic [N-1:0]    a_valid,
    output logic [N*DW-1:0] b_out,
    output logic [N-1:0]    b_valid,
    output logic            busy,
    output logic            tile_done
);

    localparam int CW     = cw(K);
    localparam int TW     = cw(K + N - 1);
    localparam int T_LAST = K + N - 2;

    feeder_state_e state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [TW-1:0] t, t_nxt;
    logic          fire;

    logic [N-1:0][DW-1:0] a_lanes, b_lanes, a_rd, b_rd, a_q, b_q;
    logic [N-1:0][CW-1:0] rk;
    logic [N-1:0]         lv, av_q, bv_q;
    logic                 busy_q, done_q;

    assign in_ready = (state == FILL);
    assign fire     = in_valid & in_ready;
    assign a_lanes  = in_a;
    assign b_lanes  = in_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
            cnt   <= '0;
            t     <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            t     <= t_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        t_nxt     = t;
        case (state)
            FILL: if (fire) begin
                if (cnt == CW'(K - 1)) begin
                    state_nxt = SEND;
                    cnt_nxt   = '0;
                    t_nxt     = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            SEND: if (t == TW'(T_LAST)) begin
                state_nxt = FILL;
                t_nxt     = '0;
            end else begin
                t_nxt = t + 1'b1;
            end
            default: state_nxt = FILL;
        endcase
    end

    // Lane i is delayed by i cycles, so it reads beat t-i this cycle.
    for (genvar i = 0; i < N; i++) begin : g_lane
        assign lv[i] = lane_ok(int'(t), i, K);
        assign rk[i] = CW'(t - TW'(i));
    end

    feeder_tile_buf #(.K(K), .N(N), .DW(DW), .CW(CW)) u_abuf (
        .clk(clk), .we(fire), .waddr(cnt), .wdata(a_lanes), .rk(rk), .rdata(a_rd)
    );

    feeder_tile_buf #(.K(K), .N(N), .DW(DW), .CW(CW)) u_bbuf (
        .clk(clk), .we(fire), .waddr(cnt), .wdata(b_lanes), .rk(rk), .rdata(b_rd)
    );

    // Output registers are zero throughout FILL: that gap restarts PE accumulators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            av_q   <= '0;
            bv_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (state == SEND);
            done_q <= busy_q & (state == FILL);
            for (int i = 0; i < N; i++) begin
                if ((state == SEND) && lv[i]) begin
                    a_q[i]  <= a_rd[i];
                    b_q[i]  <= b_rd[i];
                    av_q[i] <= 1'b1;
                    bv_q[i] <= 1'b1;
                end else begin
                    a_q[i]  <= '0;
                    b_q[i]  <= '0;
                    av_q[i] <= 1'b0;
                    bv_q[i] <= 1'b0;
                end
            end
        end
    end

    assign a_out     = a_q;
    assign b_out     = b_q;
    assign a_valid   = av_q;
    assign b_valid   = bv_q;
    assign busy      = busy_q;
    assign tile_done = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: skew timing, backpressure, gaps, reset, PE end-to-end.
module tb_systolic_feeder;

    localparam int N  = 4;
    localparam int K  = 4;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [N*DW-1:0] in_a = '0, in_b = '0;
    logic [N*DW-1:0] a_out, b_out;
    logic [N-1:0]    a_valid, b_valid;
    logic            busy, tile_done;

    systolic_feeder #(.N(N), .K(K), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .a_out(a_out), .a_valid(a_valid),
        .b_out(b_out), .b_valid(b_valid), .busy(busy), .tile_done(tile_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int ta [N][K];
    int tbm[K][N];
    int acc = 0;
    int qa [N][$];
    int qb [N][$];
    bit spot = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] lane(input logic [N*DW-1:0] v, input int i);
        return v[i*DW +: DW];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_pat(input int base);
        for (int i = 0; i < N; i++)
            for (int k = 0; k < K; k++) begin
                ta[i][k]  = base + 10*i + k;
                tbm[k][i] = base + 100*k + i;
            end
    endtask

    // Presents the current tile beat by beat; returns at #1 after the edge that took the last beat.
    task automatic send_tile(input int gap, input bit keep_valid);
        logic rdy;
        int   w;
        for (int k = 0; k < K; k++) begin
            for (int i = 0; i < N; i++) begin
                in_a[i*DW +: DW] = DW'(ta[i][k]);
                in_b[i*DW +: DW] = DW'(tbm[k][i]);
            end
            in_valid = 1'b1;
            w = 0;
            do begin
                rdy = in_ready;
                step();
                w++;
            end while (!rdy && w < 200);
            if (!rdy) chk("accept_timeout", 0, 1);
            if (!(keep_valid && k == K-1)) in_valid = 1'b0;
            if (k < K-1) repeat (gap) step();
        end
    endtask

    // Cycle c after edge E: lane i carries beat c-1-i; busy for c<=K+N-1; done at c=K+N.
    task automatic check_burst(input string nm);
        int k;
        bit ev;
        for (int c = 1; c <= K+N; c++) begin
            step();
            for (int i = 0; i < N; i++) begin
                k  = c - 1 - i;
                ev = (k >= 0) && (k < K);
                chk($sformatf("%s c%0d av%0d", nm, c, i), a_valid[i], ev);
                chk($sformatf("%s c%0d bv%0d", nm, c, i), b_valid[i], ev);
                chk($sformatf("%s c%0d a%0d", nm, c, i), lane(a_out, i), ev ? ta[i][k] : 0);
                chk($sformatf("%s c%0d b%0d", nm, c, i), lane(b_out, i), ev ? tbm[k][i] : 0);
            end
            chk($sformatf("%s c%0d busy", nm, c), busy, c <= K+N-1);
            chk($sformatf("%s c%0d done", nm, c), tile_done, c == K+N);
            chk($sformatf("%s c%0d rdy", nm, c), in_ready, c >= K+N-1);
            if (spot && c == 3) chk("a2@E+3", lane(a_out, 2), 20);
            if (spot && c == 7) chk("b3@E+7", lane(b_out, 3), 303);
        end
    endtask

    task automatic check_idle(input string nm);
        chk({nm, " a_out"}, a_out, 0);
        chk({nm, " b_out"}, b_out, 0);
        chk({nm, " a_valid"}, a_valid, 0);
        chk({nm, " b_valid"}, b_valid, 0);
        chk({nm, " busy"}, busy, 0);
        chk({nm, " done"}, tile_done, 0);
        chk({nm, " in_ready"}, in_ready, 1);
    endtask

    // Beat acceptance counter and per-lane output capture, sampled mid-cycle.
    always @(negedge clk) begin
        if (in_valid && in_ready) acc <= acc + 1;
        for (int i = 0; i < N; i++) begin
            if (a_valid[i]) qa[i].push_back(int'(lane(a_out, i)));
            if (b_valid[i]) qb[i].push_back(int'(lane(b_out, i)));
        end
    end

    // Output-stationary PE array model; accumulation restarts on a valid after a gap.
    int pa [N][N], pb [N][N], pc [N][N];
    bit pav[N][N], pbv[N][N], pprev[N][N];

    function automatic int ain(input int i, input int j);
        return (j == 0) ? int'(lane(a_out, i)) : pa[i][j-1];
    endfunction
    function automatic bit avin(input int i, input int j);
        return (j == 0) ? a_valid[i] : pav[i][j-1];
    endfunction
    function automatic int bin(input int i, input int j);
        return (i == 0) ? int'(lane(b_out, j)) : pb[i-1][j];
    endfunction
    function automatic bit bvin(input int i, input int j);
        return (i == 0) ? b_valid[j] : pbv[i-1][j];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                pa[i][j]    <= ain(i, j);
                pb[i][j]    <= bin(i, j);
                pav[i][j]   <= avin(i, j);
                pbv[i][j]   <= bvin(i, j);
                pprev[i][j] <= avin(i, j) && bvin(i, j);
                if (avin(i, j) && bvin(i, j))
                    pc[i][j] <= (pprev[i][j] ? pc[i][j] : 0) + ain(i, j) * bin(i, j);
            end
    end

    initial begin
        int acc0;
        #2;
        check_idle("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check_idle($sformatf("idle%0d", c));
        end

        // Skew pattern, back-to-back beats
        load_pat(0);
        spot = 1;
        send_tile(0, 0);
        check_burst("skew");
        spot = 0;

        // Same tile with 2-cycle source gaps: identical burst relative to last beat
        send_tile(2, 0);
        check_burst("gappy");

        // Backpressure: valid held high through SEND, two tiles streamed
        for (int i = 0; i < N; i++) begin
            qa[i].delete();
            qb[i].delete();
        end
        acc0 = acc;
        load_pat(2000);
        send_tile(0, 1);
        load_pat(3000);
        send_tile(0, 0);
        repeat (K+N+2) step();
        chk("bp beats", acc - acc0, 2*K);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("bp qa%0d len", i), qa[i].size(), 2*K);
            chk($sformatf("bp qb%0d len", i), qb[i].size(), 2*K);
            for (int n = 0; n < 2*K && n < qa[i].size() && n < qb[i].size(); n++) begin
                chk($sformatf("bp a%0d[%0d]", i, n), qa[i][n],
                    (n < K ? 2000 : 3000) + 10*i + (n % K));
                chk($sformatf("bp b%0d[%0d]", i, n), qb[i][n],
                    (n < K ? 2000 : 3000) + 100*(n % K) + i);
            end
        end

        // Reset mid-SEND at t=3, then a fresh tile
        load_pat(500);
        send_tile(0, 0);
        repeat (3) step();
        chk("pre_rst busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_idle("post_rst");
        load_pat(700);
        send_tile(0, 0);
        check_burst("fresh");

        // End-to-end: A = identity, so C = B
        for (int i = 0; i < N; i++)
            for (int k = 0; k < K; k++) begin
                ta[i][k]  = (i == k) ? 1 : 0;
                tbm[k][i] = 4*k + i + 1;
            end
        send_tile(0, 0);
        repeat (K + 3*N) step();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                chk($sformatf("c[%0d][%0d]", i, j), pc[i][j], 4*i + j + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
